alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: opcode FIFO entries; power of two, 2..16.
REQ-002 Parameter HOLD_CYCLES, default 2: cycles the decoder enable is held active per issued opcode; 1..15.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 op_valid_in  input  1  upstream opcode valid.
REQ-006 op_in  input  4  upstream ALU opcode.
REQ-007 op_ready_out  output  1  FIFO can accept; equals not-full.
REQ-008 flush_in  input  1  synchronous discard of all queued and in-flight opcodes.
REQ-009 dec_op_out  output  4  opcode presented to the 4-to-16 ALU-select decoder.
REQ-010 dec_en_n_out  output  1  decoder enable, active-low; 0 = decode dec_op_out.
REQ-011 busy_out  output  1  1 when FSM not IDLE or FIFO not empty.
REQ-012 issued_cnt_out  output  8  count of opcodes issued since reset.

Function
REQ-013 Push: when op_valid_in & op_ready_out at a rising edge, op_in is written at the FIFO tail; no bypass, no write when full.
REQ-014 FSM states: IDLE, ISSUE, GAP.
REQ-015 IDLE: dec_en_n_out=1, dec_op_out=0; FIFO non-empty -> pop head into dec_op_out, go to ISSUE, load hold counter with HOLD_CYCLES-1.
REQ-016 ISSUE: dec_en_n_out=0, dec_op_out stable; counter decrements each cycle; at 0 -> GAP.
REQ-017 GAP: exactly one cycle, dec_en_n_out=1, dec_op_out=0; then pop and go to ISSUE if FIFO non-empty, else IDLE.
REQ-018 Latency: opcode accepted at edge t into empty FIFO with FSM IDLE -> dec_en_n_out low from edge t+1 through edge t+1+HOLD_CYCLES.
REQ-019 Issue rate: back-to-back opcodes occupy HOLD_CYCLES+1 cycles each.
REQ-020 dec_op_out never changes while dec_en_n_out=0.
REQ-021 Push and pop at the same edge allowed when not full; occupancy unchanged.
REQ-022 Full: op_ready_out=0 while occupancy == DEPTH; deasserts combinationally from occupancy only.
REQ-023 issued_cnt_out increments by 1 on every transition into ISSUE; wraps 255 -> 0.
REQ-024 flush_in=1 at an edge: FIFO emptied, FSM -> IDLE, dec_en_n_out=1 and dec_op_out=0 from that edge; a same-edge push is dropped; issued_cnt_out unchanged.
REQ-025 Flush has priority over push, pop and counter decrement.

Reset
REQ-026 rst_n_in=0 asynchronously forces: FIFO empty, pointers 0, FSM IDLE, dec_en_n_out=1, dec_op_out=0, op_ready_out=1, busy_out=0, issued_cnt_out=0.
REQ-027 Reset mid-ISSUE aborts the opcode immediately; no stale opcode is issued after release.
REQ-028 First push accepted at the first rising edge with rst_n_in=1.

Configuration
REQ-029 Macro ALU_OP_SEQ_NOP_FILTER_EN defined: op_in == 4'b0000 is accepted (op_ready_out handshake completes) but not written to the FIFO and never issued.
REQ-030 Macro undefined: 4'b0000 is queued and issued like any opcode.

Verification
REQ-031 Reset release, push op 4'b0101 at edge 1 (HOLD_CYCLES=2) -> dec_en_n_out=0 with dec_op_out=5 after edges 2-3, back to 1 after edge 4, issued_cnt_out=1.
REQ-032 Push 4'b0001, 4'b0010, 4'b0011 consecutively -> issued in order, each 2 cycles low separated by exactly 1 cycle high, issued_cnt_out=3.
REQ-033 Hold FSM in ISSUE, push 5 opcodes with DEPTH=4 -> op_ready_out=0 after 4th held entry, 5th not accepted until a pop; no opcode lost or duplicated.
REQ-034 Flush during ISSUE of 4'b1100 with 2 queued -> dec_en_n_out=1 next cycle, busy_out=0, nothing further issued, count unchanged.
REQ-035 With ALU_OP_SEQ_NOP_FILTER_EN, push 4'b0000 then 4'b0111 -> only 7 issued, issued_cnt_out=1; without macro -> 0 then 7 issued, count=2.
REQ-036 Assert rst_n_in low mid-ISSUE -> dec_en_n_out=1 immediately (before next edge), all outputs at reset values.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Queues 4-bit ALU opcodes in a small FIFO and presents them one at a time
//   to an active-low-enabled 4-to-16 ALU-select decoder. Each opcode holds the
//   decoder enable low for HOLD_CYCLES cycles, followed by exactly one cycle
//   with the enable high before the next opcode may be presented.
//
//   Optional feature macro: ALU_OP_SEQ_NOP_FILTER_EN
//     When defined, opcode 4'b0000 completes the upstream handshake but is
//     discarded instead of being queued, so it is never issued.
//     When undefined, 4'b0000 is queued and issued like any other opcode.
//
//   flush_in is the synchronous clear: it discards queued and in-flight
//   opcodes while leaving issued_cnt_out untouched.

module alu_op_sequencer #(
  parameter int DEPTH       = 4,  // FIFO entries, power of two, 2..16
  parameter int HOLD_CYCLES = 2   // enable-low cycles per opcode, 1..15
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       op_valid_in,
  input  logic [3:0] op_in,
  output logic       op_ready_out,
  input  logic       flush_in,
  output logic [3:0] dec_op_out,
  output logic       dec_en_n_out,
  output logic       busy_out,
  output logic [7:0] issued_cnt_out
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [OCC_W-1:0] OCC_ZERO  = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0]       HOLD_ZERO = 4'b0000;
  localparam logic [3:0]       OP_ZERO   = 4'b0000;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // True when the opcode is the all-zero NOP encoding.
  function automatic logic is_nop_op(input logic [3:0] op);
    is_nop_op = (op == OP_ZERO);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0]       fifo_mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic [1:0]       state_r;
  logic [3:0]       hold_r;
  logic [3:0]       dec_op_r;
  logic             dec_en_n_r;
  logic [7:0]       issued_cnt_r;

  // ---------------------------------------------------------------------------
  // Next-state / control signals
  // ---------------------------------------------------------------------------
  logic             full_s;
  logic             empty_s;
  logic             accept_s;
  logic             nop_drop_s;
  logic             push_s;
  logic             pop_s;
  logic             issue_s;
  logic [OCC_W-1:0] occ_nxt_s;
  logic [1:0]       state_nxt_s;
  logic [3:0]       hold_nxt_s;
  logic [3:0]       dec_op_nxt_s;
  logic             dec_en_n_nxt_s;

  assign full_s   = (occ_r == OCC_FULL);
  assign empty_s  = (occ_r == OCC_ZERO);
  assign accept_s = op_valid_in & ~full_s;

`ifdef ALU_OP_SEQ_NOP_FILTER_EN
  // NOP opcodes complete the handshake but never reach the queue.
  assign nop_drop_s = is_nop_op(op_in);
`else
  assign nop_drop_s = 1'b0;
`endif

  // A flush at the same edge wins over any push.
  assign push_s = accept_s & ~flush_in & ~nop_drop_s;
  // The head is consumed exactly when the FSM moves into ISSUE.
  assign pop_s  = issue_s;

  // Occupancy update from the push/pop pair; simultaneous push and pop cancel.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Sequencer next-state: IDLE/GAP pop into ISSUE, ISSUE counts down to GAP.
  always_comb begin
    state_nxt_s    = state_r;
    hold_nxt_s     = hold_r;
    dec_op_nxt_s   = dec_op_r;
    dec_en_n_nxt_s = dec_en_n_r;
    issue_s        = 1'b0;
    if (flush_in) begin
      state_nxt_s    = ST_IDLE;
      hold_nxt_s     = HOLD_ZERO;
      dec_op_nxt_s   = OP_ZERO;
      dec_en_n_nxt_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_GAP: begin
          if (!empty_s) begin
            state_nxt_s    = ST_ISSUE;
            hold_nxt_s     = HOLD_LOAD;
            dec_op_nxt_s   = fifo_mem_r[rd_ptr_r];
            dec_en_n_nxt_s = 1'b0;
            issue_s        = 1'b1;
          end else begin
            state_nxt_s    = ST_IDLE;
            hold_nxt_s     = HOLD_ZERO;
            dec_op_nxt_s   = OP_ZERO;
            dec_en_n_nxt_s = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hold_r == HOLD_ZERO) begin
            state_nxt_s    = ST_GAP;
            hold_nxt_s     = HOLD_ZERO;
            dec_op_nxt_s   = OP_ZERO;
            dec_en_n_nxt_s = 1'b1;
          end else begin
            // Opcode and enable stay put while the decoder is enabled.
            state_nxt_s    = ST_ISSUE;
            hold_nxt_s     = hold_r - 4'd1;
            dec_op_nxt_s   = dec_op_r;
            dec_en_n_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s    = ST_IDLE;
          hold_nxt_s     = HOLD_ZERO;
          dec_op_nxt_s   = OP_ZERO;
          dec_en_n_nxt_s = 1'b1;
        end
      endcase
    end
  end

  // FIFO storage: write the accepted opcode at the tail slot.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= OP_ZERO;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= op_in;
    end
  end

  // FIFO pointers and occupancy; flush returns everything to empty.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else if (flush_in) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      occ_r <= occ_nxt_s;
    end
  end

  // Sequencer state, hold counter and registered decoder drive.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= ST_IDLE;
      hold_r     <= HOLD_ZERO;
      dec_op_r   <= OP_ZERO;
      dec_en_n_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      hold_r     <= hold_nxt_s;
      dec_op_r   <= dec_op_nxt_s;
      dec_en_n_r <= dec_en_n_nxt_s;
    end
  end

  // Count of opcodes issued since reset; wraps naturally at 8 bits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      issued_cnt_r <= 8'd0;
    end else if (issue_s) begin
      issued_cnt_r <= issued_cnt_r + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // ---------------------------------------------------------------------------
  assign op_ready_out   = ~full_s;
  assign dec_op_out     = dec_op_r;
  assign dec_en_n_out   = dec_en_n_r;
  assign busy_out       = (state_r != ST_IDLE) | ~empty_s;
  assign issued_cnt_out = issued_cnt_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Self-checking bench for alu_op_sequencer (DEPTH=4, HOLD_CYCLES=2).
//   A timeline reference model (opcode queue plus "decoder low from edge A to
//   edge B" bookkeeping) predicts every output after every rising edge.

module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic [3:0] op;
  logic       flush;
  logic       ready;
  logic [3:0] dec_op;
  logic       dec_en_n;
  logic       busy;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .op_valid_in   (op_valid),
    .op_in         (op),
    .op_ready_out  (ready),
    .flush_in      (flush),
    .dec_op_out    (dec_op),
    .dec_en_n_out  (dec_en_n),
    .busy_out      (busy),
    .issued_cnt_out(cnt)
  );

  int checks;
  int errors;

  // Reference model state
  int q[$];          // queued opcodes, head first
  int edge_n;        // rising edges since reset release
  int free_edge;     // earliest edge at which the next opcode may be presented
  int low_start;     // decoder enable low after edges low_start..low_end
  int low_end;
  int cur_op;
  int m_cnt;

  int   obs[$];      // opcodes seen at each falling edge of dec_en_n
  int   exp_l[$];
  logic prev_en_n;
  logic acc_d;

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic       en_n;
    logic [3:0] dop;
    logic       rdy;
    logic       bsy;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    edge_n    = 0;
    free_edge = 0;
    low_start = 0;
    low_end   = -1;
    cur_op    = 0;
    m_cnt     = 0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] o, input logic fl,
                            output logic acc);
    logic rdy;
    logic nop;
    edge_n++;
    rdy = (q.size() < DEPTH);
    acc = v && rdy;
`ifdef ALU_OP_SEQ_NOP_FILTER_EN
    nop = (o == 4'b0000);
`else
    nop = 1'b0;
`endif
    if (fl) begin
      q.delete();
      low_end   = edge_n - 1;
      free_edge = edge_n;
    end else begin
      if (q.size() > 0 && edge_n >= free_edge) begin
        cur_op    = q.pop_front();
        low_start = edge_n;
        low_end   = edge_n + HOLD - 1;
        free_edge = edge_n + HOLD + 1;
        m_cnt     = (m_cnt + 1) % 256;
      end
      if (acc && !nop) q.push_back(int'(o));
    end
  endtask

  task automatic compare_model();
    int e_en_n;
    int e_busy;
    e_en_n = (edge_n >= low_start && edge_n <= low_end) ? 0 : 1;
    e_busy = (q.size() > 0 || edge_n < free_edge) ? 1 : 0;
    check($sformatf("model_en_n@e%0d", edge_n), int'(dec_en_n), e_en_n);
    check($sformatf("model_dec_op@e%0d", edge_n), int'(dec_op), (e_en_n == 0) ? cur_op : 0);
    check($sformatf("model_ready@e%0d", edge_n), int'(ready), (q.size() < DEPTH) ? 1 : 0);
    check($sformatf("model_busy@e%0d", edge_n), int'(busy), e_busy);
    check($sformatf("model_cnt@e%0d", edge_n), int'(cnt), m_cnt);
  endtask

  task automatic step(input logic v, input logic [3:0] o, input logic fl, output logic acc);
    op_valid = v;
    op       = o;
    flush    = fl;
    @(posedge clk);
    model_edge(v, o, fl, acc);
    #1;
    compare_model();
    if (prev_en_n && !dec_en_n) obs.push_back(int'(dec_op));
    prev_en_n = dec_en_n;
    op_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push_op(input logic [3:0] o, output logic saw_full);
    logic acc;
    logic done;
    done     = 1'b0;
    saw_full = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      step(1'b1, o, 1'b0, acc);
      if (!ready) saw_full = 1'b1;
      if (acc) begin
        done = 1'b1;
        exp_l.push_back(int'(o));
      end
    end
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (q.size() == 0 && edge_n >= free_edge) done = 1'b1;
      else step(1'b0, 4'd0, 1'b0, acc_d);
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  task automatic check_issue_list(input string name);
    check({name, "_count"}, obs.size(), exp_l.size());
    for (int i = 0; i < exp_l.size(); i++) begin
      check($sformatf("%s_op%0d", name, i), (obs.size() > i) ? obs[i] : -1, exp_l[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic sf;
    logic full_seen;
    logic found;
    int   c0;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op        = 4'd0;
    flush     = 1'b0;
    prev_en_n = 1'b1;
    model_reset();

    //            v     op     en_n  dop    rdy   bsy   cnt
    vecs[0]  = '{1'b1, 4'd5, 1'b1, 4'd0, 1'b1, 1'b1, 8'd0};
    vecs[1]  = '{1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 8'd1};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 8'd1};
    vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 8'd1};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 4'd1, 1'b1, 4'd0, 1'b1, 1'b1, 8'd1};
    vecs[6]  = '{1'b1, 4'd2, 1'b0, 4'd1, 1'b1, 1'b1, 8'd2};
    vecs[7]  = '{1'b1, 4'd3, 1'b0, 4'd1, 1'b1, 1'b1, 8'd2};
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 8'd2};
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 8'd3};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 8'd3};
    vecs[11] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 8'd3};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 8'd4};
    vecs[13] = '{1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 8'd4};
    vecs[14] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 8'd4};
    vecs[15] = '{1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0, 8'd4};

    // Reset values while rst_n is held low
    repeat (2) @(posedge clk);
    #1;
    check("rst_en_n", int'(dec_en_n), 1);
    check("rst_dec_op", int'(dec_op), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt", int'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single opcode 5, then 1,2,3 back to back
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].op, 1'b0, acc_d);
      check($sformatf("tbl_en_n[%0d]", i), int'(dec_en_n), int'(vecs[i].en_n));
      check($sformatf("tbl_dec_op[%0d]", i), int'(dec_op), int'(vecs[i].dop));
      check($sformatf("tbl_ready[%0d]", i), int'(ready), int'(vecs[i].rdy));
      check($sformatf("tbl_busy[%0d]", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("tbl_cnt[%0d]", i), int'(cnt), int'(vecs[i].cnt));
    end

    // Fill the FIFO while the decoder is busy: no loss, no duplication
    obs.delete();
    exp_l.delete();
    full_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push_op(4'(k + 8), sf);
      if (sf) full_seen = 1'b1;
    end
    drain();
    check("full_seen", int'(full_seen), 1);
    check_issue_list("fill");

    // Flush during the issue of 12 with two opcodes queued behind it
    obs.delete();
    exp_l.delete();
    push_op(4'd12, sf);
    push_op(4'd3, sf);
    push_op(4'd9, sf);
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (!dec_en_n && dec_op == 4'd12) found = 1'b1;
      else step(1'b0, 4'd0, 1'b0, acc_d);
    end
    check("flush_wait_issue12", int'(found), 1);
    c0 = m_cnt;
    step(1'b1, 4'd6, 1'b1, acc_d);
    check("flush_en_n", int'(dec_en_n), 1);
    check("flush_busy", int'(busy), 0);
    check("flush_cnt", int'(cnt), c0);
    repeat (6) step(1'b0, 4'd0, 1'b0, acc_d);
    check("flush_issued_total", obs.size(), 1);
    check("flush_cnt_after", int'(cnt), c0);

    // Zero opcode followed by 7
    obs.delete();
    exp_l.delete();
    c0 = int'(cnt);
    push_op(4'd0, sf);
    push_op(4'd7, sf);
    drain();
`ifdef ALU_OP_SEQ_NOP_FILTER_EN
    exp_l.delete();
    exp_l.push_back(7);
    check("nop_cnt", int'(cnt), (c0 + 1) % 256);
`else
    check("nop_cnt", int'(cnt), (c0 + 2) % 256);
`endif
    check_issue_list("nop");

    // Asynchronous reset in the middle of an issue
    push_op(4'd10, sf);
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      if (!dec_en_n) found = 1'b1;
      else step(1'b0, 4'd0, 1'b0, acc_d);
    end
    check("arst_wait_issue", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_en_n", int'(dec_en_n), 1);
    check("arst_dec_op", int'(dec_op), 0);
    check("arst_ready", int'(ready), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_cnt", int'(cnt), 0);
    model_reset();
    prev_en_n = 1'b1;
    obs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step(1'b0, 4'd0, 1'b0, acc_d);
    check("arst_no_stale_issue", obs.size(), 0);

    // Randomised traffic with occasional flushes; long enough to wrap the count
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           acc_d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
